draw_fillctrl: RTL and testbench
================================

Name: draw_fillctrl

Overview:
- AXI write-master drawing engine that fills a rectangle of the VRAM frame buffer with a single 32-bit ARGB colour.
- Sits upstream of the display path: it produces the pixel data that the display read-master later fetches from DDR.
- Writes whole 64-bit words, two pixels per beat, using INCR bursts that never cross a 4 KB boundary.
- Register block drives START and the geometry inputs, and receives BUSY/DONE/ERR.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, AXI address width
C_M_AXI_DATA_WIDTH, 64, AXI data width; fixed at 64 (2 pixels/beat)
MAX_BURST, 16, maximum beats per burst (1..16)

Ports:
ACLK  in  1  system clock
ARST  in  1  reset, asynchronous, active-high
START  in  1  one-cycle pulse; accepted only in IDLE
DRAWADDR  in  32  frame base byte address, 8-byte aligned
STRIDE  in  13  line pitch in bytes, multiple of 8
POSX  in  11  left pixel, even
POSY  in  11  top line
WIDTH  in  11  pixels per line, even, 0 allowed
HEIGHT  in  11  lines, 0 allowed
COLOR  in  32  fill colour
BUSY  out  1  high from START accept until DONE
DONE  out  1  one-cycle pulse at completion
ERR  out  1  sticky; set on BRESP != OKAY, cleared by next accepted START
M_AXI_AWADDR  out  32  burst address
M_AXI_AWLEN  out  8  beats-1
M_AXI_AWVALID  out  1  address valid
M_AXI_AWREADY  in  1  address ready
M_AXI_WDATA  out  64  {COLOR,COLOR}
M_AXI_WSTRB  out  8  always 8'hFF
M_AXI_WLAST  out  1  last beat of burst
M_AXI_WVALID  out  1  data valid
M_AXI_WREADY  in  1  data ready
M_AXI_BRESP  in  2  write response
M_AXI_BVALID  in  1  response valid
M_AXI_BREADY  out  1  response ready
Fixed AW attributes (SIZE=3'b011, BURST=INCR, CACHE=4'b0011) are tied at the top level, not in this block.

Behaviour:
- Reset: state IDLE; BUSY, DONE, ERR, AWVALID, WVALID, WLAST, BREADY all 0; AWADDR, AWLEN 0.
- On START in IDLE, latch all inputs.
  - Line address = DRAWADDR + POSY*STRIDE + POSX*4 (32-bit wrap).
  - Beats per line = WIDTH/2.
  - START while BUSY is ignored.
- If WIDTH==0 or HEIGHT==0: BUSY is high for exactly 1 cycle, then DONE pulses; no AXI traffic.
- States and transitions:
  - IDLE -> CALC on START.
  - CALC computes burst length = min(MAX_BURST, remaining beats in line, (4096 - addr[11:0])/8), then -> AW.
  - AW asserts AWVALID with AWLEN = len-1; holds until AWREADY; -> W.
  - W asserts WVALID and counts beats on WVALID&&WREADY. WLAST is high on the final beat. After the last handshake -> B.
  - B asserts BREADY; on BVALID, ERR |= (BRESP != 0), then -> NEXT.
  - NEXT advances the address by len*8 and decrements remaining beats.
    - Line not finished -> CALC.
    - Line finished, lines remaining: line address += STRIDE -> CALC.
    - Otherwise -> FIN.
  - FIN pulses DONE, drops BUSY -> IDLE.
- Exactly one burst is outstanding (AW, then W, then B); AW and W never overlap.
- AXI rule: once VALID is asserted, address, length and data stay stable until READY.
- Geometry is not clipped; the caller guarantees the rectangle lies within the frame.
- ARST mid-burst aborts immediately to the reset state; the interconnect is reset by the same ARESETN.
- Counter widths:
  - Beat counter: 11 bits.
  - Line counter: 11 bits.
  - POSY*STRIDE: 24-bit product, zero-extended to 32 bits.

Decomposition:
- Shared package draw_pkg holds:
  - state encoding (IDLE, CALC, AW, W, B, NEXT, FIN);
  - BYTES_PER_BEAT=8, PAGE_BYTES=4096;
  - AXI_RESP_OKAY=2'b00.
- One sub-module, draw_burstcalc, is natural: a combinational min-of-three burst-length calculator, testable standalone.
- The rest stays in draw_fillctrl.

Test Plan:
- Single-burst fill.
  - Stimulus: DRAWADDR=0x2000_0000, STRIDE=2560, POS=(0,0), WIDTH=32, HEIGHT=1, COLOR=0xFF00FF00; always-ready slave.
  - Response: one AW with AWADDR=0x2000_0000, AWLEN=15; 16 beats of 0xFF00FF00_FF00FF00; WLAST on beat 16; DONE after B; ERR=0.
- 4 KB split.
  - Stimulus: POSX=1016, POSY=0, WIDTH=16, DRAWADDR=0.
  - Response: bursts at 0x0FE0 with AWLEN=3 and 0x1000 with AWLEN=3.
- Multi-line with backpressure.
  - Stimulus: POS=(2,3), WIDTH=40, HEIGHT=2, STRIDE=2560; random AWREADY/WREADY stalls.
  - Response: line 0 at 7688 (AWLEN 15, then AWLEN 3); line 1 at 10248 (same pattern); signals stable while stalled; 40 beats total.
- Zero size.
  - Stimulus: WIDTH=0.
  - Response: no AWVALID; DONE pulses 2 cycles after START.
- Error response.
  - Stimulus: BRESP=2'b10 on the first burst.
  - Response: ERR=1 stays set through DONE; the next START clears it.
- Reset mid-W.
  - Stimulus: assert ARST during beat 5.
  - Response: all outputs 0 asynchronously; IDLE after release; a new START works normally.

Source files
------------

// File: rtl/draw_pkg.sv
// ----------------------------------------------------------------------------
// draw_pkg: shared state encoding and AXI/page constants for the fill engine
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package draw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_AW   = 3'd2,
    ST_W    = 3'd3,
    ST_B    = 3'd4,
    ST_NEXT = 3'd5,
    ST_FIN  = 3'd6
  } state_t;

  localparam int          BYTES_PER_BEAT = 8;
  localparam int          PAGE_BYTES     = 4096;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

endpackage

`default_nettype wire

// File: rtl/draw_fillctrl_if.sv
// ----------------------------------------------------------------------------
// draw_fillctrl_if: AXI write-channel bundle (AW, W, B) of the fill engine
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface draw_fillctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);

  logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [7:0]              M_AXI_AWLEN;
  logic                    M_AXI_AWVALID;
  logic                    M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                    M_AXI_WLAST;
  logic                    M_AXI_WVALID;
  logic                    M_AXI_WREADY;
  logic [1:0]              M_AXI_BRESP;
  logic                    M_AXI_BVALID;
  logic                    M_AXI_BREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWVALID,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_BREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWVALID,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_BREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );

endinterface

`default_nettype wire

// File: rtl/draw_burstcalc.sv
// ----------------------------------------------------------------------------
// draw_burstcalc: burst length = min(MAX_BURST, beats left in line, beats to 4 KB)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module draw_burstcalc
  import draw_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic [8:0]  page_word_i,
  input  logic [10:0] rem_beats_i,
  output logic [10:0] len_o
);

  logic [10:0] page_beats;
  logic [10:0] lim;

  // Beat-aligned word offset inside the 4 KB page gives the room left before it
  assign page_beats = 11'(PAGE_BYTES / BYTES_PER_BEAT) - 11'(page_word_i);

  always_comb begin
    lim = 11'(MAX_BURST);
    if (page_beats < lim) lim = page_beats;
    if (rem_beats_i < lim) lim = rem_beats_i;
    len_o = lim;
  end

endmodule

`default_nettype wire

// File: rtl/draw_fillctrl.sv
// ----------------------------------------------------------------------------
// draw_fillctrl: AXI write master filling a frame-buffer rectangle with one colour
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module draw_fillctrl
  import draw_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int MAX_BURST          = 16
) (
  input  logic                          ACLK,
  input  logic                          ARST,
  input  logic                          START,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] DRAWADDR,
  input  logic [12:0]                   STRIDE,
  input  logic [10:0]                   POSX,
  input  logic [10:0]                   POSY,
  input  logic [10:0]                   WIDTH,
  input  logic [10:0]                   HEIGHT,
  input  logic [31:0]                   COLOR,
  output logic                          BUSY,
  output logic                          DONE,
  output logic                          ERR,
  draw_fillctrl_if.master               m_axi
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;

  state_t        state_q, state_d;
  logic [AW-1:0] line_addr_q, line_addr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [12:0]   stride_q, stride_d;
  logic [10:0]   bpl_q, bpl_d;
  logic [10:0]   rem_q, rem_d;
  logic [10:0]   lines_q, lines_d;
  logic [31:0]   color_q, color_d;
  logic [7:0]    awlen_q, awlen_d;
  logic [10:0]   beat_q, beat_d;
  logic          err_q, err_d;

  logic [23:0]   row_off;
  logic [AW-1:0] line_base;
  logic [AW-1:0] next_line;
  logic [10:0]   burst_len;
  logic [10:0]   burst_beats;
  logic [10:0]   rem_after;
  logic [AW-1:0] burst_bytes;

  draw_burstcalc #(
    .MAX_BURST (MAX_BURST)
  ) u_burstcalc (
    .page_word_i (addr_q[11:3]),
    .rem_beats_i (rem_q),
    .len_o       (burst_len)
  );

  assign row_off     = 24'(POSY) * 24'(STRIDE);
  assign line_base   = DRAWADDR + AW'(row_off) + AW'({POSX, 2'b00});
  assign next_line   = line_addr_q + AW'(stride_q);
  assign burst_beats = 11'(awlen_q) + 11'd1;
  assign rem_after   = rem_q - burst_beats;
  assign burst_bytes = AW'(burst_beats) * AW'(BYTES_PER_BEAT);

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    bpl_d       = bpl_q;
    rem_d       = rem_q;
    lines_d     = lines_q;
    color_d     = color_q;
    awlen_d     = awlen_q;
    beat_d      = beat_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          err_d       = 1'b0;
          line_addr_d = line_base;
          addr_d      = line_base;
          stride_d    = STRIDE;
          bpl_d       = WIDTH >> 1;
          rem_d       = WIDTH >> 1;
          lines_d     = HEIGHT;
          color_d     = COLOR;
          state_d     = ST_CALC;
        end
      end
      ST_CALC: begin
        // rem_q is only zero here for an empty rectangle; NEXT reloads it per line
        if (rem_q == 11'd0 || lines_q == 11'd0) begin
          state_d = ST_FIN;
        end else begin
          awlen_d = 8'(burst_len - 11'd1);
          beat_d  = 11'd0;
          state_d = ST_AW;
        end
      end
      ST_AW: begin
        if (m_axi.M_AXI_AWREADY) state_d = ST_W;
      end
      ST_W: begin
        if (m_axi.M_AXI_WREADY) begin
          if (beat_q == 11'(awlen_q)) state_d = ST_B;
          else                        beat_d  = beat_q + 11'd1;
        end
      end
      ST_B: begin
        if (m_axi.M_AXI_BVALID) begin
          if (m_axi.M_AXI_BRESP != AXI_RESP_OKAY) err_d = 1'b1;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        addr_d = addr_q + burst_bytes;
        rem_d  = rem_after;
        if (rem_after != 11'd0) begin
          state_d = ST_CALC;
        end else if (lines_q > 11'd1) begin
          lines_d     = lines_q - 11'd1;
          line_addr_d = next_line;
          addr_d      = next_line;
          rem_d       = bpl_q;
          state_d     = ST_CALC;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      state_q     <= ST_IDLE;
      line_addr_q <= '0;
      addr_q      <= '0;
      stride_q    <= '0;
      bpl_q       <= '0;
      rem_q       <= '0;
      lines_q     <= '0;
      color_q     <= '0;
      awlen_q     <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      bpl_q       <= bpl_d;
      rem_q       <= rem_d;
      lines_q     <= lines_d;
      color_q     <= color_d;
      awlen_q     <= awlen_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
    end
  end

  assign BUSY = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign DONE = (state_q == ST_FIN);
  assign ERR  = err_q;

  assign m_axi.M_AXI_AWADDR  = addr_q;
  assign m_axi.M_AXI_AWLEN   = awlen_q;
  assign m_axi.M_AXI_AWVALID = (state_q == ST_AW);
  assign m_axi.M_AXI_WDATA   = {(C_M_AXI_DATA_WIDTH/32){color_q}};
  assign m_axi.M_AXI_WSTRB   = '1;
  assign m_axi.M_AXI_WVALID  = (state_q == ST_W);
  assign m_axi.M_AXI_WLAST   = (state_q == ST_W) && (beat_q == 11'(awlen_q));
  assign m_axi.M_AXI_BREADY  = (state_q == ST_B);

endmodule

`default_nettype wire

// File: tb/tb_draw_fillctrl.sv
// ----------------------------------------------------------------------------
// tb_draw_fillctrl: randomized AXI slave plus byte-level rectangle reference model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_draw_fillctrl;

  localparam int MAXB = 16;

  typedef struct {
    string       name;
    logic [31:0] drawaddr;
    logic [12:0] stride;
    logic [10:0] posx, posy, width, height;
    logic [31:0] color;
    bit          stall;
    bit          poke;
    int          err_burst;
    int          exp_bursts;
    int          exp_beats;
    logic [31:0] exp_addr0;
    logic [7:0]  exp_len0;
  } vec_t;

  logic        ACLK, ARST, START;
  logic [31:0] DRAWADDR, COLOR;
  logic [12:0] STRIDE;
  logic [10:0] POSX, POSY, WIDTH, HEIGHT;
  logic        BUSY, DONE, ERR;

  draw_fillctrl_if ax ();

  draw_fillctrl dut (
    .ACLK     (ACLK),
    .ARST     (ARST),
    .START    (START),
    .DRAWADDR (DRAWADDR),
    .STRIDE   (STRIDE),
    .POSX     (POSX),
    .POSY     (POSY),
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .COLOR    (COLOR),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR),
    .m_axi    (ax)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_err = 0;

  bit          stall_en = 1'b0;
  int          err_at = -1;
  int          b_idx = 0;
  int          w_beats_run = 0;
  logic [31:0] cur_color = '0;
  logic [39:0] got_aw[$];
  logic [39:0] exp_q[$];
  int          exp_beats;

  // monitor state
  bit          aw_wait_prev = 1'b0, w_wait_prev = 1'b0;
  logic [31:0] prev_awaddr;
  logic [7:0]  prev_awlen, cur_len;
  logic [63:0] prev_wdata;
  logic        prev_wlast;
  int          cur_beat = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Slave: randomise readies on the falling edge, then observe what the next rising edge will see
  always begin
    @(negedge ACLK);
    if (ARST) begin
      ax.M_AXI_AWREADY = 1'b0;
      ax.M_AXI_WREADY  = 1'b0;
      ax.M_AXI_BVALID  = 1'b0;
      ax.M_AXI_BRESP   = 2'b00;
      aw_wait_prev = 1'b0;
      w_wait_prev  = 1'b0;
      cur_beat     = 0;
    end else begin
      ax.M_AXI_AWREADY = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      ax.M_AXI_WREADY  = stall_en ? ($urandom_range(0, 1) == 0) : 1'b1;
      ax.M_AXI_BVALID  = ax.M_AXI_BREADY &&
                         (ax.M_AXI_BVALID || !stall_en || ($urandom_range(0, 1) == 0));
      ax.M_AXI_BRESP   = (b_idx == err_at) ? 2'b10 : 2'b00;
    end
    #1;
    if (!ARST) begin
      if (ax.M_AXI_AWVALID || ax.M_AXI_WVALID)
        chk("aw_w_overlap", 64'(ax.M_AXI_AWVALID && ax.M_AXI_WVALID), 64'd0);
      if (aw_wait_prev)
        chk("aw_stable", {23'd0, ax.M_AXI_AWVALID, ax.M_AXI_AWLEN, ax.M_AXI_AWADDR},
            {23'd0, 1'b1, prev_awlen, prev_awaddr});
      if (w_wait_prev) begin
        chk("w_stable_valid", 64'(ax.M_AXI_WVALID), 64'd1);
        chk("w_stable_data", ax.M_AXI_WDATA, prev_wdata);
        chk("w_stable_last", 64'(ax.M_AXI_WLAST), 64'(prev_wlast));
      end
      aw_wait_prev = ax.M_AXI_AWVALID && !ax.M_AXI_AWREADY;
      w_wait_prev  = ax.M_AXI_WVALID && !ax.M_AXI_WREADY;
      prev_awaddr  = ax.M_AXI_AWADDR;
      prev_awlen   = ax.M_AXI_AWLEN;
      prev_wdata   = ax.M_AXI_WDATA;
      prev_wlast   = ax.M_AXI_WLAST;
      if (ax.M_AXI_AWVALID && ax.M_AXI_AWREADY) begin
        got_aw.push_back({ax.M_AXI_AWADDR, ax.M_AXI_AWLEN});
        cur_len  = ax.M_AXI_AWLEN;
        cur_beat = 0;
      end
      if (ax.M_AXI_WVALID && ax.M_AXI_WREADY) begin
        chk("wdata", ax.M_AXI_WDATA, {cur_color, cur_color});
        chk("wstrb", 64'(ax.M_AXI_WSTRB), 64'hFF);
        chk("wlast", 64'(ax.M_AXI_WLAST), 64'(cur_beat == int'(cur_len)));
        cur_beat++;
        w_beats_run++;
      end
      if (ax.M_AXI_BVALID && ax.M_AXI_BREADY) b_idx++;
    end
  end

  // Reference: walk each line in bytes, cutting at 128-byte bursts and 4 KB pages
  function automatic void build_model(input vec_t v);
    logic [31:0] a;
    int bytes, chunk, to_page;
    exp_q.delete();
    exp_beats = 0;
    for (int ln = 0; ln < int'(v.height); ln++) begin
      a = v.drawaddr + 32'(v.posy) * 32'(v.stride) + 32'(v.posx) * 32'd4
          + 32'(ln) * 32'(v.stride);
      bytes = int'(v.width) * 4;
      while (bytes > 0) begin
        to_page = 4096 - int'(a[11:0]);
        chunk = bytes;
        if (chunk > MAXB * 8) chunk = MAXB * 8;
        if (chunk > to_page) chunk = to_page;
        exp_q.push_back({a, 8'(chunk / 8 - 1)});
        exp_beats += chunk / 8;
        a += 32'(chunk);
        bytes -= chunk;
      end
    end
  endfunction

  function automatic vec_t mk(string n, logic [31:0] da, int st, int px, int py, int w, int h,
                              logic [31:0] c, bit s, bit pk, int eb, int nb, int nbt,
                              logic [31:0] a0, int l0);
    vec_t v;
    v.name = n; v.drawaddr = da; v.stride = 13'(st);
    v.posx = 11'(px); v.posy = 11'(py); v.width = 11'(w); v.height = 11'(h);
    v.color = c; v.stall = s; v.poke = pk; v.err_burst = eb;
    v.exp_bursts = nb; v.exp_beats = nbt; v.exp_addr0 = a0; v.exp_len0 = 8'(l0);
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(BUSY), 64'd0);
    chk({tag, "_done"}, 64'(DONE), 64'd0);
    chk({tag, "_err"}, 64'(ERR), 64'd0);
    chk({tag, "_awvalid"}, 64'(ax.M_AXI_AWVALID), 64'd0);
    chk({tag, "_wvalid"}, 64'(ax.M_AXI_WVALID), 64'd0);
    chk({tag, "_wlast"}, 64'(ax.M_AXI_WLAST), 64'd0);
    chk({tag, "_bready"}, 64'(ax.M_AXI_BREADY), 64'd0);
    chk({tag, "_awaddr"}, 64'(ax.M_AXI_AWADDR), 64'd0);
    chk({tag, "_awlen"}, 64'(ax.M_AXI_AWLEN), 64'd0);
  endtask

  task automatic run_fill(input vec_t v);
    int  cycles;
    bit  exp_err;
    build_model(v);
    exp_err = (v.err_burst >= 0) && (v.err_burst < exp_q.size());
    got_aw.delete();
    w_beats_run = 0;
    b_idx       = 0;
    err_at      = v.err_burst;
    stall_en    = v.stall;
    cur_color   = v.color;
    @(negedge ACLK);
    DRAWADDR = v.drawaddr; STRIDE = v.stride; POSX = v.posx; POSY = v.posy;
    WIDTH = v.width; HEIGHT = v.height; COLOR = v.color; START = 1'b1;
    @(negedge ACLK);
    START = 1'b0;
    #2;
    chk({v.name, "_busy_on_start"}, 64'(BUSY), 64'd1);
    chk({v.name, "_err_cleared"}, 64'(ERR), 64'd0);
    cycles = 1;
    while (!DONE && cycles < 4000) begin
      @(negedge ACLK);
      if (v.poke && cycles == 3) begin
        DRAWADDR = v.drawaddr ^ 32'h0000_0100;
        WIDTH    = 11'd2;
        START    = 1'b1;
      end else begin
        START = 1'b0;
      end
      #2;
      cycles++;
    end
    START = 1'b0;
    chk({v.name, "_done_seen"}, 64'(DONE), 64'd1);
    if (exp_q.size() == 0) chk({v.name, "_zero_done_latency"}, 64'(cycles), 64'd2);
    chk({v.name, "_n_bursts"}, 64'(got_aw.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_aw.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_burst%0d_addr_len", v.name, i), 64'(got_aw[i]), 64'(exp_q[i]));
    chk({v.name, "_beats"}, 64'(w_beats_run), 64'(exp_beats));
    chk({v.name, "_err_at_done"}, 64'(ERR), 64'(exp_err));
    if (v.exp_bursts >= 0) begin
      chk({v.name, "_tbl_bursts"}, 64'(got_aw.size()), 64'(v.exp_bursts));
      chk({v.name, "_tbl_beats"}, 64'(w_beats_run), 64'(v.exp_beats));
      if (v.exp_bursts > 0 && got_aw.size() > 0)
        chk({v.name, "_tbl_first"}, 64'(got_aw[0]), 64'({v.exp_addr0, v.exp_len0}));
    end
    @(negedge ACLK);
    #2;
    chk({v.name, "_done_one_cycle"}, 64'(DONE), 64'd0);
    chk({v.name, "_idle_busy"}, 64'(BUSY), 64'd0);
    chk({v.name, "_err_hold"}, 64'(ERR), 64'(exp_err));
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    ARST = 1'b0; START = 1'b0;
    DRAWADDR = '0; STRIDE = '0; POSX = '0; POSY = '0; WIDTH = '0; HEIGHT = '0; COLOR = '0;
    ax.M_AXI_AWREADY = 1'b0; ax.M_AXI_WREADY = 1'b0;
    ax.M_AXI_BVALID = 1'b0; ax.M_AXI_BRESP = 2'b00;
    #1 ARST = 1'b1;
    #1 check_idle_outputs("reset");
    repeat (3) @(negedge ACLK);
    ARST = 1'b0;

    //        name        drawaddr       strd  px  py  w   h  color          stl pk err nb nbt addr0          len0
    tbl[0] = mk("single",   32'h2000_0000, 2560, 0,    0, 32, 1, 32'hFF00FF00, 0, 0, -1, 1, 16, 32'h2000_0000, 15);
    tbl[1] = mk("split4k",  32'h0000_0000, 2560, 1016, 0, 16, 1, 32'h11223344, 0, 0, -1, 2, 8,  32'h0000_0FE0, 3);
    tbl[2] = mk("multiln",  32'h0000_0000, 2560, 2,    3, 40, 2, 32'hCAFEBABE, 1, 1, -1, 4, 40, 32'd7688,      15);
    tbl[3] = mk("zero_w",   32'h0000_1000, 2560, 0,    0, 0,  3, 32'h00000000, 0, 0, -1, 0, 0,  32'd0,         0);
    tbl[4] = mk("zero_h",   32'h0000_1000, 2560, 4,    2, 8,  0, 32'h00000000, 0, 0, -1, 0, 0,  32'd0,         0);
    tbl[5] = mk("errresp",  32'h1000_0000, 64,   0,    0, 32, 2, 32'hDEADBEEF, 0, 0, 0,  2, 32, 32'h1000_0000, 15);
    tbl[6] = mk("errclear", 32'h3000_0008, 64,   0,    0, 2,  1, 32'h0F0F0F0F, 0, 0, -1, 1, 1,  32'h3000_0008, 0);
    tbl[7] = mk("w34",      32'h0000_0100, 512,  0,    0, 34, 1, 32'h5A5A5A5A, 1, 0, -1, 2, 17, 32'h0000_0100, 15);
    for (int i = 0; i < 8; i++) run_fill(tbl[i]);

    // Reset asserted while the fifth data beat is being presented
    got_aw.delete(); w_beats_run = 0; b_idx = 0; err_at = -1; stall_en = 1'b0;
    cur_color = 32'h12345678;
    @(negedge ACLK);
    DRAWADDR = 32'h4000_0000; STRIDE = 13'd256; POSX = '0; POSY = '0;
    WIDTH = 11'd32; HEIGHT = 11'd1; COLOR = cur_color; START = 1'b1;
    @(negedge ACLK);
    START = 1'b0;
    for (int i = 0; i < 100 && w_beats_run < 5; i++) begin
      @(negedge ACLK);
      #2;
    end
    chk("midrst_reached_beat5", 64'(w_beats_run), 64'd5);
    #1 ARST = 1'b1;
    #1 check_idle_outputs("midrst");
    repeat (2) @(negedge ACLK);
    ARST = 1'b0;
    #2 chk("midrst_idle_busy", 64'(BUSY), 64'd0);
    run_fill(tbl[0]);

    for (int n = 0; n < 20; n++) begin
      rv.name      = $sformatf("rand%0d", n);
      rv.drawaddr  = $urandom() & 32'hFFFF_FFF8;
      rv.stride    = 13'($urandom_range(0, 1023) * 8);
      rv.posx      = 11'($urandom_range(0, 1023) * 2);
      rv.posy      = 11'($urandom_range(0, 2047));
      rv.width     = 11'($urandom_range(0, 48) * 2);
      rv.height    = 11'($urandom_range(0, 3));
      rv.color     = $urandom();
      rv.stall     = 1'($urandom_range(0, 1));
      rv.poke      = 1'($urandom_range(0, 1));
      rv.err_burst = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
      rv.exp_bursts = -1; rv.exp_beats = 0; rv.exp_addr0 = '0; rv.exp_len0 = '0;
      run_fill(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
